// File: rtl/rs232_tx_fifo.sv
// Buffered 8N1 RS-232 transmitter: a valid/ready byte FIFO feeds a registered serialiser.
// Define RS232_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module rs232_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RS232_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    state_t        state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          txd_reg, txd_next;
    logic          push, pop, baud_tick;
    logic [7:0]    head;
`ifdef RS232_TX_PARITY_EN
    logic          parity_reg, parity_next;
`endif

    assign head       = mem[rd_ptr_reg];
    assign in_ready   = (count_reg != CW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign baud_tick  = (baud_reg == BW'(CLKS_PER_BIT - 1));
    assign fifo_count = count_reg;
    assign txd        = txd_reg;
    assign tx_busy    = (state_reg != IDLE);

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
`ifdef RS232_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = head;
`ifdef RS232_TX_PARITY_EN
                    parity_next = ^head;
`endif
                    state_next = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
`ifdef RS232_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        shift_next = head;
`ifdef RS232_TX_PARITY_EN
                        parity_next = ^head;
`endif
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: begin
                baud_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    // The line level is decided from the next state so txd is a clean flop output.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef RS232_TX_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            txd_reg    <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
`ifdef RS232_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
`ifdef RS232_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
